// File: rtl/muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_seq_pkg : op encodings, FSM state type and default width.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_dp.sv
// ---------------------------------------------------------------------------
// muldiv_dp : operand capture, radix-2 shift registers, shared adder, sign fixup.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_dp
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_capture,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic               r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_acc, r_sh, r_mb;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_neg_q, r_neg_r;

  logic               w_is_div;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH+1:0]   w_x, w_y, w_sum;
  logic               w_cin;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_is_div      = (r_op == OP_DIV);
  assign o_div_by_zero = w_is_div && (r_b == '0);
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

  // Unsigned magnitudes keep the most-negative operand representable.
  assign w_mag_a = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_mag_b = r_b[WIDTH-1] ? -r_b : r_b;

  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_cin = 1'b0;
    if (w_is_div) begin
      w_x   = {1'b0, r_acc, r_sh[WIDTH-1]};
      w_y   = ~{2'b00, r_mb};
      w_cin = 1'b1;
    end else begin
      w_x = {2'b00, r_acc};
      w_y = r_sh[0] ? {2'b00, r_mb} : '0;
    end
  end

  assign w_sum    = w_x + w_y + {{(WIDTH+1){1'b0}}, w_cin};
  assign w_prod   = {r_acc, r_sh};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -r_sh : r_sh;
  assign w_rem    = r_neg_r ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sh    <= '0;
      r_mb    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (i_capture) begin
        r_op <= i_op;
        r_a  <= i_a;
        r_b  <= i_b;
      end
      if (i_load) begin
        r_neg_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
        r_neg_r <= r_a[WIDTH-1];
        r_acc   <= '0;
        r_sh    <= w_mag_a;
        r_mb    <= w_mag_b;
      end else if (i_step) begin
        if (w_is_div) begin
          // Sign bit of the trial subtraction decides restore vs keep.
          if (!w_sum[WIDTH+1]) begin
            r_acc <= w_sum[WIDTH-1:0];
            r_sh  <= {r_sh[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_x[WIDTH-1:0];
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
          end
        end else begin
          {r_acc, r_sh} <= {w_sum[WIDTH:0], r_sh[WIDTH-1:1]};
        end
      end
      if (i_fix) begin
        if (w_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          {r_hi, r_lo} <= w_prod_s;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : sequential signed multiply/divide, control FSM and step counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done, r_div_zero;
  logic            w_capture, w_load, w_step, w_fix, w_dz_case;

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

  assign w_capture = (r_state == S_IDLE) && start;
  assign w_load    = (r_state == S_PREP);
  assign w_step    = (r_state == S_ITER);
  assign w_fix     = (r_state == S_FIXUP) && !w_dz_case;

  // Divide-by-zero passes through FIXUP with the result write suppressed,
  // which places its done pulse two edges after the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_PREP;
            r_busy  <= 1'b1;
          end
        end
        S_PREP: begin
          r_cnt   <= '0;
          r_state <= w_dz_case ? S_FIXUP : S_ITER;
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_done     <= 1'b1;
          r_div_zero <= w_dz_case;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_div_zero <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  muldiv_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk          (clk),
    .reset        (reset),
    .i_capture    (w_capture),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_fix        (w_fix),
    .i_op         (op),
    .i_a          (a),
    .i_b          (b),
    .o_div_by_zero(w_dz_case),
    .o_hi         (hi),
    .o_lo         (lo)
  );

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq : directed vectors with a queue scoreboard and done monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int W      = 32;
  localparam int LAT    = W + 2;
  localparam int LAT_DZ = 2;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   edge_n    = 0;
  int   done_seen = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        check("spurious_done", {63'b0, done}, 64'b0);
      end else begin
        e = sb_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", div_zero, e.dz);
        check("latency_edge", edge_n, e.due);
      end
    end
  end

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int poke);
    int lat;
    lat = edz ? LAT_DZ : LAT;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back('{hi: eh, lo: el, dz: edz, due: edge_n + 1 + lat});
    @(negedge clk);
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    check("busy_during_op", busy, 1);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 1; b = 1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < LAT + 10 && sb_q.size() > 0; k++) @(negedge clk);
    check("done_timeout_pending", sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    check("hold_hi", hi, eh);
    check("hold_lo", lo, el);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;

    run_op(OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0);
    run_op(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
    run_op(OP_MULT, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 0);
    run_op(OP_MULT, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0);
    run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
    run_op(OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 0);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
    run_op(OP_DIV,  32'd3,        32'd7,        32'h00000003, 32'h00000000, 1'b0, 0);
    run_op(OP_DIV,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 5);
    run_op(OP_DIV,  32'd5,        32'd2,        32'h00000001, 32'h00000002, 1'b0, 0);
    run_op(OP_DIV,  32'd5,        32'd0,        32'h00000001, 32'h00000002, 1'b1, 0);

    // Abort mid-operation: start ignored at iteration 5, reset at iteration 10.
    d0 = done_seen;
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    repeat (LAT + 6) @(negedge clk);
    check("abort_no_done", done_seen, d0);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    repeat (LAT + 6) @(negedge clk);
    check("rst_start_no_done", done_seen, d0);

    run_op(OP_MULT, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
